// File: rtl/pipe_issue_arbiter.sv
// pipe_issue_arbiter
// Round-robin front end for one shared, free-running, fixed-latency
// 4-operand pipeline. The winning operands are registered onto the
// datapath inputs. A tag shift register, matched to the pipeline depth,
// carries each operation's requester ID alongside it. When an operation
// leaves the pipeline, its result is registered and returned to the
// requester that issued it, together with a one-cycle valid strobe.

module pipe_issue_arbiter #(
    parameter int W   = 10,
    parameter int LAT = 3,
    parameter int CW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req0_valid,
    input  logic [4*W-1:0]   req0_ops,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4*W-1:0]   req1_ops,
    output logic             req1_ready,
    output logic [W-1:0]     pa,
    output logic [W-1:0]     pb,
    output logic [W-1:0]     pc,
    output logic [W-1:0]     pd,
    input  logic [W-1:0]     pf,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [W-1:0]     rsp_data,
    output logic             busy,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Saturating increment: all-ones is sticky, so the counter never wraps.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic             last_grant_r;  // ID of the most recent winner
    logic [LAT:0]     tag_valid_r;   // stage j holds the op accepted j+1 edges ago
    logic [LAT:0]     tag_id_r;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic             win_id_s;
    logic [4*W-1:0]   win_ops_s;

    // Round-robin grant: a lone requester always wins (no idle penalty); on contention the one that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!en) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (last_grant_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Winner selection for the operand registers and the tag entry.
    always_comb begin
        accept_s  = grant0_s | grant1_s;
        win_id_s  = grant1_s;
        if (grant1_s) begin
            win_ops_s = req1_ops;
        end else begin
            win_ops_s = req0_ops;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign busy       = |tag_valid_r;

    // Operand registers feeding the datapath; they hold between accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= {W{1'b0}};
            pb <= {W{1'b0}};
            pc <= {W{1'b0}};
            pd <= {W{1'b0}};
        end else if (accept_s) begin
            pa <= win_ops_s[4*W-1 -: W];
            pb <= win_ops_s[3*W-1 -: W];
            pc <= win_ops_s[2*W-1 -: W];
            pd <= win_ops_s[W-1:0];
        end
    end

    // Arbitration history; starting at 1 gives requester 0 the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= win_id_s;
        end
    end

    // Tag pipeline shifts every edge; stage LAT lines up with pf for its op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= {(LAT+1){1'b0}};
            tag_id_r    <= {(LAT+1){1'b0}};
        end else begin
            tag_valid_r <= {tag_valid_r[LAT-1:0], accept_s};
            tag_id_r    <= {tag_id_r[LAT-1:0], win_id_s};
        end
    end

    // Response capture: latch pf while stage LAT is valid and strobe the owning requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data   <= {W{1'b0}};
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            rsp0_valid <= tag_valid_r[LAT] & ~tag_id_r[LAT];
            rsp1_valid <= tag_valid_r[LAT] &  tag_id_r[LAT];
            if (tag_valid_r[LAT]) begin
                rsp_data <= pf;
            end
        end
    end

    // Per-requester accepted-operation counters, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= {CW{1'b0}};
            cnt1 <= {CW{1'b0}};
        end else begin
            if (grant0_s) begin
                cnt0 <= sat_inc(cnt0);
            end
            if (grant1_s) begin
                cnt1 <= sat_inc(cnt1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Bench for pipe_issue_arbiter. A stub datapath returns pa delayed by LAT
// edges. Expected responses are pushed to a queue when an accept is
// predicted, and popped by a monitor when a response strobe appears.
// A second instance with CW=4 exercises counter saturation.

module tb_pipe_issue_arbiter;

    localparam int W   = 10;
    localparam int LAT = 3;
    localparam int CW  = 16;

    logic clk, rst_n, en;
    logic req0_valid, req1_valid;
    logic [4*W-1:0] req0_ops, req1_ops;
    logic req0_ready, req1_ready;
    logic [W-1:0] pa, pb, pc, pd, pf, rsp_data;
    logic rsp0_valid, rsp1_valid, busy;
    logic [CW-1:0] cnt0, cnt1;

    logic s_req0_ready, s_req1_ready;
    logic [W-1:0] s_pa, s_pb, s_pc, s_pd, s_rsp_data;
    logic s_rsp0_valid, s_rsp1_valid, s_busy;
    logic [3:0] s_cnt0, s_cnt1;

    pipe_issue_arbiter #(.W(W), .LAT(LAT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0_valid(req0_valid), .req0_ops(req0_ops), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_ops(req1_ops), .req1_ready(req1_ready),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pf(pf),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    pipe_issue_arbiter #(.W(W), .LAT(LAT), .CW(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0_valid(req0_valid), .req0_ops(req0_ops), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_ops(req1_ops), .req1_ready(s_req1_ready),
        .pa(s_pa), .pb(s_pb), .pc(s_pc), .pd(s_pd), .pf(pf),
        .rsp0_valid(s_rsp0_valid), .rsp1_valid(s_rsp1_valid), .rsp_data(s_rsp_data),
        .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub datapath: f = a, LAT edges after a changes.
    logic [W-1:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= pa;
        d2 <= d1;
        d3 <= d2;
    end
    assign pf = d3;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        bit           id;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_x;
    int   total = 0;
    int   bad   = 0;
    bit   m_last;
    int   mcnt0, mcnt1, ms0;
    logic [1:0] obs_rdy, exp_rdy;
    int   acc_edge;

    function automatic logic [4*W-1:0] mk(input logic [W-1:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    // Drive one cycle from a negedge; predict the grant and push the expected response.
    task automatic step(input bit v0, input logic [4*W-1:0] o0,
                        input bit v1, input logic [4*W-1:0] o1, input bit e);
        exp_t x;
        req0_valid = v0; req0_ops = o0;
        req1_valid = v1; req1_ops = o1;
        en = e;
        #1;
        obs_rdy = {req1_ready, req0_ready};
        exp_rdy = 2'b00;
        if (e) begin
            if (v0 && v1)  exp_rdy = m_last ? 2'b01 : 2'b10;
            else if (v0)   exp_rdy = 2'b01;
            else if (v1)   exp_rdy = 2'b10;
        end
        if (exp_rdy != 2'b00) begin
            x.id   = exp_rdy[1];
            x.data = exp_rdy[1] ? o1[4*W-1 -: W] : o0[4*W-1 -: W];
            x.due  = edge_cnt + 1 + LAT + 1;
            sbq.push_back(x);
            m_last   = exp_rdy[1];
            acc_edge = edge_cnt + 1;
            if (exp_rdy[1]) mcnt1++;
            else begin
                mcnt0++;
                ms0 = (ms0 == 15) ? 15 : ms0 + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // Scoreboard monitor: every strobe must match the queue head, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid || rsp1_valid) begin
                total++;
                if (rsp0_valid && rsp1_valid) begin
                    bad++;
                    $display("FAIL rsp_both: rsp0=1 rsp1=1 at edge %0d, required one-hot", edge_cnt);
                end else if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: rsp1=%0b data=%h at edge %0d, required no strobe",
                             rsp1_valid, rsp_data, edge_cnt);
                end else begin
                    mon_x = sbq.pop_front();
                    if (mon_x.id !== rsp1_valid || mon_x.data !== rsp_data || mon_x.due != edge_cnt) begin
                        bad++;
                        $display("FAIL rsp_match: got id=%0b data=%h edge=%0d, required id=%0b data=%h edge=%0d",
                                 rsp1_valid, rsp_data, edge_cnt, mon_x.id, mon_x.data, mon_x.due);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due <= edge_cnt) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: no strobe at edge %0d, required id=%0b data=%h",
                         edge_cnt, sbq[0].id, sbq[0].data);
                mon_x = sbq.pop_front();
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_ops = '0; req1_ops = '0;
        m_last = 1'b1; mcnt0 = 0; mcnt1 = 0; ms0 = 0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({pa, pb, pc, pd, rsp_data} !== {(5*W){1'b0}} || {rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_async: pa=%h pb=%h pc=%h pd=%h rsp=%h v=%b%b busy=%b, required all 0",
                     pa, pb, pc, pd, rsp_data, rsp0_valid, rsp1_valid, busy);
        end
        total++;
        if (cnt0 !== 16'h0000 || cnt1 !== 16'h0000) begin
            bad++;
            $display("FAIL reset_cnt: cnt0=%h cnt1=%h, required 0", cnt0, cnt1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, '0, 1'b1);
        total++;
        if (obs_rdy !== 2'b00 || busy !== 1'b0 || pa !== 10'h000) begin
            bad++;
            $display("FAIL reset_idle: rdy=%b busy=%b pa=%h, required 00 0 000", obs_rdy, busy, pa);
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk(10'h042, 10'h001, 10'h002, 10'h003), 1'b1, mk(10'h011, 10'h004, 10'h005, 10'h006), 1'b1);
            total++;
            if (obs_rdy !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL alt_grant[%0d]: rdy=%b, required %b", i, obs_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        idle(LAT + 3);
        total++;
        if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin
            bad++;
            $display("FAIL alt_cnt: cnt0=%0d cnt1=%0d, required 2 2", cnt0, cnt1);
        end
    endtask

    task automatic test_single();
        step(1'b1, mk(10'h032, 10'h025, 10'h034, 10'h011), 1'b0, '0, 1'b1);
        total++;
        if (obs_rdy !== 2'b01) begin
            bad++;
            $display("FAIL single_grant: rdy=%b, required 01", obs_rdy);
        end
        total++;
        if ({pa, pb, pc, pd} !== {10'h032, 10'h025, 10'h034, 10'h011} || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_ops: pa=%h pb=%h pc=%h pd=%h busy=%b, required 032 025 034 011 1",
                     pa, pb, pc, pd, busy);
        end
        idle(LAT + 3);
        total++;
        if (cnt0 !== 16'(mcnt0) || cnt1 !== 16'(mcnt1)) begin
            bad++;
            $display("FAIL single_cnt: cnt0=%0d cnt1=%0d, required %0d %0d", cnt0, cnt1, mcnt0, mcnt1);
        end
    endtask

    task automatic test_req1_only();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, mk(10'(10'h150 + i), 10'h000, 10'h000, 10'h000), 1'b1);
            total++;
            if (obs_rdy !== 2'b10) begin
                bad++;
                $display("FAIL req1_grant[%0d]: rdy=%b, required 10", i, obs_rdy);
            end
        end
        idle(LAT + 3);
    endtask

    task automatic test_en_drop();
        int k2;
        step(1'b1, mk(10'h101, 10'h000, 10'h000, 10'h000), 1'b0, '0, 1'b1);
        step(1'b1, mk(10'h1AB, 10'h000, 10'h000, 10'h000), 1'b0, '0, 1'b1);
        k2 = acc_edge;
        for (int j = 0; j < 7; j++) begin
            step(1'b1, mk(10'h3FF, 10'h000, 10'h000, 10'h000), 1'b1, mk(10'h2EE, 10'h000, 10'h000, 10'h000), 1'b0);
            total++;
            if (obs_rdy !== 2'b00) begin
                bad++;
                $display("FAIL en_rdy[%0d]: rdy=%b, required 00", j, obs_rdy);
            end
            total++;
            if (busy !== (edge_cnt < k2 + LAT + 1)) begin
                bad++;
                $display("FAIL en_busy[%0d]: busy=%b, required %b", j, busy, (edge_cnt < k2 + LAT + 1));
            end
        end
        idle(2);
    endtask

    task automatic test_rst_mid();
        step(1'b1, mk(10'h2C3, 10'h000, 10'h000, 10'h000), 1'b0, '0, 1'b1);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({pa, pb, pc, pd, rsp_data} !== {(5*W){1'b0}} || busy !== 1'b0 || cnt0 !== 16'h0000 || cnt1 !== 16'h0000) begin
            bad++;
            $display("FAIL rst_mid: pa=%h rsp=%h busy=%b cnt0=%h cnt1=%h, required all 0",
                     pa, rsp_data, busy, cnt0, cnt1);
        end
        sbq.delete();
        m_last = 1'b1; mcnt0 = 0; mcnt1 = 0; ms0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        step(1'b1, mk(10'h0C4, 10'h000, 10'h000, 10'h000), 1'b1, mk(10'h0D5, 10'h000, 10'h000, 10'h000), 1'b1);
        total++;
        if (obs_rdy !== 2'b01) begin
            bad++;
            $display("FAIL rst_first_grant: rdy=%b, required 01", obs_rdy);
        end
        idle(LAT + 3);
    endtask

    task automatic test_saturation();
        logic [W-1:0] av;
        for (int i = 0; i < 20; i++) begin
            av = 10'(i + 16);
            step(1'b1, mk(av, 10'h000, 10'h000, 10'h000), 1'b0, '0, 1'b1);
            total++;
            if (s_cnt0 !== 4'(ms0) || cnt0 !== 16'(mcnt0)) begin
                bad++;
                $display("FAIL sat_cnt[%0d]: s_cnt0=%0d cnt0=%0d, required %0d %0d", i, s_cnt0, cnt0, ms0, mcnt0);
            end
        end
        total++;
        if (s_cnt0 !== 4'hF) begin
            bad++;
            $display("FAIL sat_final: s_cnt0=%h, required f", s_cnt0);
        end
        idle(LAT + 3);
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_req1_only();
        test_en_drop();
        test_rst_mid();
        test_saturation();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_issue_arbiter.md
Name: pipe_issue_arbiter

Overview:
- Shares one free-running, fixed-latency 4-operand pipeline (operands a, b, c, d; result f; all W bits) between two requesters.
- Arbitrates round-robin, registers the winning operands onto the datapath inputs, and tracks requester ID through a tag shift register matched to the pipeline depth.
- Returns f to the requester that issued it, with a response-valid strobe.
- Sits between the requesting logic and the pipeline instance; the pipeline itself is unchanged.

Parameters:
W, 10, operand/result width
LAT, 3, datapath latency in clk edges from operand change to matching f
CW, 16, width of per-requester issue counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  issue enable; low blocks new grants, in-flight ops still drain
req0_valid  in  1  requester 0 has an operation
req0_ops  in  4*W  {a,b,c,d}, a in MSBs
req0_ready  out  1  grant to requester 0 (combinational)
req1_valid  in  1  requester 1 has an operation
req1_ops  in  4*W  {a,b,c,d}
req1_ready  out  1  grant to requester 1 (combinational)
pa, pb, pc, pd  out  W each  registered operands to datapath
pf  in  W  datapath result f
rsp0_valid  out  1  one-cycle strobe, result for requester 0
rsp1_valid  out  1  one-cycle strobe, result for requester 1
rsp_data  out  W  registered result
busy  out  1  any op in flight (OR of tag-valid stages)
cnt0, cnt1  out  CW each  accepted-op counts, saturating

Behaviour:
- Reset (async, rst_n=0): pa..pd=0, rsp_data=0, rsp0/1_valid=0, all tag stages invalid, cnt0=cnt1=0, last_grant=1 (requester 0 has priority first). Outputs are forced to these values immediately on reset assertion, independent of clk.
- Grant, combinational:
  - en=0: both readys 0.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - At most one ready is high per cycle; ready never asserts without the matching valid.
- Accept = valid & ready at edge k. At edge k:
  - pa..pd load the winner's ops.
  - last_grant updates to the winner.
  - Tag stage 0 loads {valid=1, id}.
  - The winner's counter increments, saturating at 2^CW-1.
- No accept at edge k: pa..pd hold their value; tag stage 0 loads invalid.
- Tag pipeline has stages 0..LAT and shifts every edge. Stage LAT aligns with pf carrying the result of the ops loaded at edge k, i.e. after edge k+LAT.
- At edge k+LAT+1: rsp_data <= pf. rspN_valid <= stage LAT valid & (id==N), so the strobe is high for exactly the cycle after edge k+LAT+1.
- Accept-to-response latency is LAT+1 edges. Issue rate is one per cycle, and back-to-back grants are allowed. Responses have no backpressure.
- When no response is due, rsp_data holds its last value.
- Simultaneous accept and response in the same cycle is normal; there is no interaction.
- en deasserted mid-stream: no new accepts; outstanding tags drain and produce responses; busy falls the edge after the last stage clears.
- Reset mid-operation: all in-flight tags are discarded; no response is emitted for them after rst_n rises.
- Counter saturation: holds at all-ones; does not wrap.
- rsp_data width is W; no truncation or extension.

Test Plan:
- Stub datapath (pf = pa delayed LAT edges, LAT=3). Single req0 {a=0x32,b=0x25,c=0x34,d=0x11} accepted at edge 1 -> pa=0x32 after edge 1; rsp0_valid high only after edge 5 with rsp_data=0x032; rsp1_valid stays 0; cnt0=1.
- req0 and req1 both valid continuously for 4 cycles (req0 a=0x42, req1 a=0x11) -> grants 0,1,0,1; responses alternate rsp0/rsp1 on consecutive cycles, data 0x42/0x11; cnt0=cnt1=2.
- Only req1 valid for 3 cycles -> req1 granted every cycle (no idle-cycle penalty); three consecutive rsp1_valid strobes.
- en dropped 1 cycle after 2 accepts -> readys 0 while en=0; both responses still appear; busy deasserts after the second response's tag leaves stage LAT.
- rst_n pulsed low 2 cycles after an accept -> outputs zero immediately; no rsp strobe ever appears for that op; first grant after reset goes to req0.
- cnt0 preloaded by 2^CW accepts (CW reduced to 4 for the test) -> cnt0 stops at 0xF.
